// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared encodings and EX/MEM control bundle for the MIPS datapath
package mips_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_RSVD = 2'b11;

   localparam logic [4:0] REG_RA = 5'd31;

   typedef struct packed {
      logic       load;
      logic       store;
      logic       rf_enable;
      logic       link;
      logic       sign_ext;
      logic [1:0] size;
   } exmem_ctrl_t;

endpackage

// File: rtl/exmem_stage_if.sv
// rtl/exmem_stage_if.sv - EX-side inputs and MEM-side outputs of the EX/MEM register
interface exmem_stage_if #(
   parameter int PC_W = 9
);
   logic            ex_valid;
   logic [31:0]     ex_alu_result;
   logic [31:0]     ex_store_data;
   logic [4:0]      ex_dest;
   logic [PC_W-1:0] ex_pc8;
   logic            ex_load;
   logic            ex_store;
   logic            ex_rf_enable;
   logic            ex_link;
   logic [1:0]      ex_size;
   logic            ex_signed;

   logic            mem_valid;
   logic [31:0]     mem_addr;
   logic [31:0]     mem_wdata;
   logic [3:0]      mem_be;
   logic [4:0]      mem_dest;
   logic [PC_W-1:0] mem_pc8;
   logic            mem_load;
   logic            mem_store;
   logic            mem_rf_enable;
   logic            mem_link;
   logic            mem_signed;
   logic [1:0]      mem_size;
   logic            mem_misaligned;
   logic            fwd_valid;
   logic [31:0]     fwd_data;
   logic            load_pending;

   modport master (
      output ex_valid, ex_alu_result, ex_store_data, ex_dest, ex_pc8,
             ex_load, ex_store, ex_rf_enable, ex_link, ex_size, ex_signed,
      input  mem_valid, mem_addr, mem_wdata, mem_be, mem_dest, mem_pc8,
             mem_load, mem_store, mem_rf_enable, mem_link, mem_signed,
             mem_size, mem_misaligned, fwd_valid, fwd_data, load_pending
   );

   modport slave (
      input  ex_valid, ex_alu_result, ex_store_data, ex_dest, ex_pc8,
             ex_load, ex_store, ex_rf_enable, ex_link, ex_size, ex_signed,
      output mem_valid, mem_addr, mem_wdata, mem_be, mem_dest, mem_pc8,
             mem_load, mem_store, mem_rf_enable, mem_link, mem_signed,
             mem_size, mem_misaligned, fwd_valid, fwd_data, load_pending
   );
endinterface

// File: rtl/exmem_stage_store_align.sv
// rtl/exmem_stage_store_align.sv - little-endian lane replication, byte enables and alignment check
module store_align
   import mips_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  addr,
   input  logic [31:0] data,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic        misaligned
);

   always_comb begin
      wdata      = data;
      be         = 4'b0000;
      misaligned = 1'b0;
      case (size)
         SZ_BYTE: begin
            wdata = {4{data[7:0]}};
            be    = 4'b0001 << addr;
         end
         SZ_HALF: begin
            wdata      = {2{data[15:0]}};
            be         = addr[1] ? 4'b1100 : 4'b0011;
            misaligned = addr[0];
         end
         SZ_WORD: begin
            be         = 4'b1111;
            misaligned = (addr != 2'b00);
         end
         default: misaligned = 1'b1;
      endcase
   end

endmodule

// File: rtl/exmem_stage.sv
// rtl/exmem_stage.sv - EX/MEM pipeline register with store alignment, stall/flush and forwarding view
module exmem_stage
   import mips_pkg::*;
#(
   parameter int PC_W = 9
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         stall,
   input  logic         flush,
   exmem_stage_if.slave bus
);

   logic [31:0] al_wdata;
   logic [3:0]  al_be;
   logic        al_mis;

   store_align u_align (
      .size       (bus.ex_size),
      .addr       (bus.ex_alu_result[1:0]),
      .data       (bus.ex_store_data),
      .wdata      (al_wdata),
      .be         (al_be),
      .misaligned (al_mis)
   );

   exmem_ctrl_t ctrl_d;
   logic        mis_d;
   logic [3:0]  be_d;

   // Misaligned accesses keep mem_valid but lose their memory and write-back side effects.
   always_comb begin
      mis_d            = bus.ex_valid & (bus.ex_load | bus.ex_store) & al_mis;
      ctrl_d.load      = bus.ex_valid & bus.ex_load      & ~mis_d;
      ctrl_d.store     = bus.ex_valid & bus.ex_store     & ~mis_d;
      ctrl_d.rf_enable = bus.ex_valid & bus.ex_rf_enable & ~mis_d;
      ctrl_d.link      = bus.ex_valid & bus.ex_link;
      ctrl_d.sign_ext  = bus.ex_signed;
      ctrl_d.size      = bus.ex_size;
      be_d             = (ctrl_d.load | ctrl_d.store) ? al_be : 4'b0000;
   end

   logic            valid_q;
   logic [31:0]     addr_q;
   logic [31:0]     wdata_q;
   logic [3:0]      be_q;
   logic [4:0]      dest_q;
   logic [PC_W-1:0] pc8_q;
   exmem_ctrl_t     ctrl_q;
   logic            mis_q;

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         dest_q  <= '0;
         pc8_q   <= '0;
         ctrl_q  <= '0;
         mis_q   <= 1'b0;
      end else if (!stall) begin
         valid_q <= bus.ex_valid;
         addr_q  <= bus.ex_alu_result;
         wdata_q <= al_wdata;
         be_q    <= be_d;
         dest_q  <= bus.ex_dest;
         pc8_q   <= bus.ex_pc8;
         ctrl_q  <= ctrl_d;
         mis_q   <= mis_d;
      end
   end

   assign bus.mem_valid      = valid_q;
   assign bus.mem_addr       = addr_q;
   assign bus.mem_wdata      = wdata_q;
   assign bus.mem_be         = be_q;
   assign bus.mem_dest       = dest_q;
   assign bus.mem_pc8        = pc8_q;
   assign bus.mem_load       = ctrl_q.load;
   assign bus.mem_store      = ctrl_q.store;
   assign bus.mem_rf_enable  = ctrl_q.rf_enable;
   assign bus.mem_link       = ctrl_q.link;
   assign bus.mem_signed     = ctrl_q.sign_ext;
   assign bus.mem_size       = ctrl_q.size;
   assign bus.mem_misaligned = mis_q;

   // Loads cannot forward from MEM; their consumers must wait one more cycle.
   assign bus.fwd_valid    = valid_q & ctrl_q.rf_enable & ~ctrl_q.load & (dest_q != 5'd0);
   assign bus.fwd_data     = ctrl_q.link ? {{(32-PC_W){1'b0}}, pc8_q} : addr_q;
   assign bus.load_pending = valid_q & ctrl_q.load & (dest_q != 5'd0);

endmodule

// File: tb/tb_exmem_stage.sv
// tb/tb_exmem_stage.sv - directed scoreboard bench for exmem_stage
module tb_exmem_stage;

   localparam int PC_W = 9;

   logic clk = 1'b0;
   logic reset, stall, flush;

   exmem_stage_if #(.PC_W(PC_W)) bus ();

   exmem_stage #(.PC_W(PC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .stall (stall),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            valid;
      logic [31:0]     addr;
      logic [31:0]     wdata;
      logic [3:0]      be;
      logic [4:0]      dest;
      logic [PC_W-1:0] pc8;
      logic            load, store, rf, link, sgn, mis;
      logic [1:0]      size;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic exp_t zero_state();
      exp_t e;
      e.valid = 0; e.addr = 0; e.wdata = 0; e.be = 0; e.dest = 0; e.pc8 = 0;
      e.load = 0; e.store = 0; e.rf = 0; e.link = 0; e.sgn = 0; e.mis = 0; e.size = 0;
      return e;
   endfunction

   function automatic exp_t model();
      exp_t       e;
      logic [1:0] a;
      logic [3:0] lanes;
      logic       bad;
      logic [31:0] d;
      e = zero_state();
      a = bus.ex_alu_result[1:0];
      d = bus.ex_store_data;
      case (bus.ex_size)
         2'b00:   begin e.wdata = {4{d[7:0]}};  lanes = 4'b0001 << a;                 bad = 0;          end
         2'b01:   begin e.wdata = {2{d[15:0]}}; lanes = a[1] ? 4'b1100 : 4'b0011;     bad = a[0];       end
         2'b10:   begin e.wdata = d;            lanes = 4'b1111;                      bad = (a != 0);   end
         default: begin e.wdata = d;            lanes = 4'b0000;                      bad = 1;          end
      endcase
      e.valid = bus.ex_valid;
      e.addr  = bus.ex_alu_result;
      e.dest  = bus.ex_dest;
      e.pc8   = bus.ex_pc8;
      e.size  = bus.ex_size;
      e.sgn   = bus.ex_signed;
      e.mis   = bus.ex_valid & (bus.ex_load | bus.ex_store) & bad;
      e.load  = bus.ex_valid & bus.ex_load & ~e.mis;
      e.store = bus.ex_valid & bus.ex_store & ~e.mis;
      e.rf    = bus.ex_valid & bus.ex_rf_enable & ~e.mis;
      e.link  = bus.ex_valid & bus.ex_link;
      e.be    = (e.load | e.store) ? lanes : 4'b0000;
      return e;
   endfunction

   task automatic check_out(input string tag, input exp_t e);
      logic        fv, lp;
      logic [31:0] fd;
      fv = e.valid & e.rf & ~e.load & (e.dest != 0);
      lp = e.valid & e.load & (e.dest != 0);
      fd = e.link ? {{(32-PC_W){1'b0}}, e.pc8} : e.addr;
      chk({tag, ".valid"}, bus.mem_valid, e.valid);
      chk({tag, ".addr"},  bus.mem_addr,  e.addr);
      chk({tag, ".wdata"}, bus.mem_wdata, e.wdata);
      chk({tag, ".be"},    bus.mem_be,    e.be);
      chk({tag, ".dest"},  bus.mem_dest,  e.dest);
      chk({tag, ".pc8"},   bus.mem_pc8,   e.pc8);
      chk({tag, ".ctl"},
          {bus.mem_load, bus.mem_store, bus.mem_rf_enable, bus.mem_link, bus.mem_signed, bus.mem_size},
          {e.load, e.store, e.rf, e.link, e.sgn, e.size});
      chk({tag, ".mis"},   bus.mem_misaligned, e.mis);
      chk({tag, ".fwd_valid"},    bus.fwd_valid,    fv);
      chk({tag, ".fwd_data"},     bus.fwd_data,     fd);
      chk({tag, ".load_pending"}, bus.load_pending, lp);
   endtask

   task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] dest, input logic [PC_W-1:0] pc8,
                        input logic ld, input logic st, input logic rf, input logic lk,
                        input logic [1:0] sz, input logic sg);
      bus.ex_valid = v; bus.ex_alu_result = alu; bus.ex_store_data = sd;
      bus.ex_dest = dest; bus.ex_pc8 = pc8; bus.ex_load = ld; bus.ex_store = st;
      bus.ex_rf_enable = rf; bus.ex_link = lk; bus.ex_size = sz; bus.ex_signed = sg;
   endtask

   task automatic step(input string tag, input logic rs, input logic st, input logic fl);
      exp_t e;
      reset = rs; stall = st; flush = fl;
      if (rs || fl)  e = zero_state();
      else if (st)   e = cur;
      else           e = model();
      cur = e;
      sb.push_back(e);
      @(posedge clk);
      #1;
      check_out(tag, sb.pop_front());
   endtask

   initial begin
      reset = 1; stall = 0; flush = 0;
      drive(1, 32'hFFFF_FFFF, 32'h1234_5678, 5'd7, 9'h1FF, 0, 1, 1, 1, 2'b10, 1);
      step("reset", 1, 0, 0);

      drive(1, 32'h100, 32'hDEADBEEF, 5'd0, 9'h010, 0, 1, 0, 0, 2'b10, 0);
      step("sw", 0, 0, 0);
      chk("sw.wdata_lit", bus.mem_wdata, 32'hDEADBEEF);
      chk("sw.be_lit", bus.mem_be, 4'b1111);

      drive(1, 32'h103, 32'h0000_00A5, 5'd0, 9'h014, 0, 1, 0, 0, 2'b00, 0);
      step("sb", 0, 0, 0);
      chk("sb.wdata_lit", bus.mem_wdata, 32'hA5A5A5A5);
      chk("sb.be_lit", bus.mem_be, 4'b1000);

      drive(1, 32'h102, 32'hCAFE_1234, 5'd0, 9'h018, 0, 1, 0, 0, 2'b01, 0);
      step("sh_hi", 0, 0, 0);
      chk("sh_hi.be_lit", bus.mem_be, 4'b1100);

      drive(1, 32'h101, 32'hCAFE_1234, 5'd0, 9'h01C, 0, 1, 0, 0, 2'b01, 0);
      step("sh_mis", 0, 0, 0);
      chk("sh_mis.lit", {bus.mem_misaligned, bus.mem_store, bus.mem_be, bus.mem_valid}, {1'b1, 1'b0, 4'b0000, 1'b1});

      drive(1, 32'h1234, 32'h0, 5'd8, 9'h020, 0, 0, 1, 0, 2'b10, 0);
      step("alu", 0, 0, 0);
      chk("alu.fwd_lit", {bus.fwd_valid, bus.fwd_data}, {1'b1, 32'h1234});

      drive(1, 32'h5555, 32'h0, 5'd31, 9'h0A4, 0, 0, 1, 1, 2'b10, 0);
      step("link", 0, 0, 0);
      chk("link.fwd_lit", bus.fwd_data, 32'h0000_00A4);

      drive(1, 32'h200, 32'h0, 5'd9, 9'h028, 1, 0, 1, 0, 2'b10, 1);
      step("lw", 0, 0, 0);
      chk("lw.lp_lit", {bus.load_pending, bus.fwd_valid}, 2'b10);

      drive(1, 32'h202, 32'h0, 5'd0, 9'h02C, 1, 0, 1, 0, 2'b01, 1);
      step("lh_r0", 0, 0, 0);

      drive(1, 32'h300, 32'h0, 5'd4, 9'h030, 1, 0, 1, 0, 2'b11, 0);
      step("ld_rsvd", 0, 0, 0);

      drive(0, 32'h304, 32'h0000_00BB, 5'd6, 9'h034, 0, 1, 1, 1, 2'b00, 0);
      step("invalid", 0, 0, 0);

      drive(1, 32'h77, 32'h0, 5'd5, 9'h038, 0, 0, 1, 0, 2'b10, 0);
      step("pre_stall", 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         drive(1, 32'h400 + i, 32'h1111_0000 + i, 5'd10 + 5'(i), 9'h040 + 9'(i), 0, 1, 0, 0, 2'b00, 0);
         step("stall", 0, 1, 0);
      end
      chk("stall.addr_lit", bus.mem_addr, 32'h77);
      step("release", 0, 0, 0);
      chk("release.addr_lit", bus.mem_addr, 32'h402);

      drive(1, 32'h500, 32'hAAAA_BBBB, 5'd3, 9'h050, 0, 1, 0, 0, 2'b10, 0);
      step("stall_flush", 0, 1, 1);
      chk("stall_flush.lit", {bus.mem_valid, bus.mem_be}, 5'b0);

      drive(1, 32'h600, 32'h0, 5'd12, 9'h060, 1, 0, 1, 0, 2'b10, 0);
      step("pre_rst", 0, 0, 0);
      step("hold", 0, 1, 0);
      step("rst_in_stall", 1, 1, 0);
      step("post_rst", 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
